// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: two requester ports plus SRAM pins.
// slave = arbiter side, master = requesters and SRAM device side.
interface sram_arbiter_if;
  logic        i_a_cs;
  logic        i_a_we;
  logic [17:0] i_a_addr;
  logic [7:0]  i_a_dat;
  logic [7:0]  o_a_dat;
  logic        o_a_ack;
  logic        i_b_cs;
  logic        i_b_we;
  logic [17:0] i_b_addr;
  logic [7:0]  i_b_dat;
  logic [7:0]  o_b_dat;
  logic        o_b_ack;
  logic [17:0] o_sram_addr;
  logic [7:0]  o_sram_dat;
  logic        o_sram_dat_oe;
  logic [7:0]  i_sram_dat;
  logic        o_sram_cs_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;

  modport slave (
    input  i_a_cs, i_a_we, i_a_addr, i_a_dat,
    output o_a_dat, o_a_ack,
    input  i_b_cs, i_b_we, i_b_addr, i_b_dat,
    output o_b_dat, o_b_ack,
    output o_sram_addr, o_sram_dat, o_sram_dat_oe,
    input  i_sram_dat,
    output o_sram_cs_n, o_sram_oe_n, o_sram_we_n
  );

  modport master (
    output i_a_cs, i_a_we, i_a_addr, i_a_dat,
    input  o_a_dat, o_a_ack,
    output i_b_cs, i_b_we, i_b_addr, i_b_dat,
    input  o_b_dat, o_b_ack,
    input  o_sram_addr, o_sram_dat, o_sram_dat_oe,
    output i_sram_dat,
    input  o_sram_cs_n, o_sram_oe_n, o_sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and setup/strobe/hold SRAM sequencer.
// Ports: i_clk, i_reset (async high), bus (requesters A/B + SRAM pins).
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  sram_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  rd_q, rd_d;

  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        doe_q, doe_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;

  logic        pick_b;
  logic        busy_d;
  logic        drive_d;

  // gnt/last: 0 = port A, 1 = port B
  assign pick_b = bus.i_b_cs &&
                  (!bus.i_a_cs || !last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_a_cs || bus.i_b_cs) begin
          gnt_d   = pick_b;
          we_d    = pick_b ? bus.i_b_we
                           : bus.i_a_we;
          addr_d  = pick_b ? bus.i_b_addr
                           : bus.i_a_addr;
          wdat_d  = pick_b ? bus.i_b_dat
                           : bus.i_a_dat;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) rd_d = bus.i_sram_dat;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: state_d = S_DONE;
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state so that
  // every SRAM output comes straight from a flop.
  always_comb begin
    busy_d  = (state_d == S_SETUP) ||
              (state_d == S_STROBE) ||
              (state_d == S_HOLD);
    drive_d = (state_d == S_SETUP) ||
              (state_d == S_STROBE);
    cs_n_d  = !busy_d;
    oe_n_d  = !(drive_d && !we_d);
    we_n_d  = !(state_d == S_STROBE && we_d);
    doe_d   = busy_d && we_d;
    a_ack_d = (state_d == S_DONE) && !gnt_d;
    b_ack_d = (state_d == S_DONE) && gnt_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 18'd0;
      wdat_q  <= 8'd0;
      rd_q    <= 8'd0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
    end
  end

  assign bus.o_sram_addr   = addr_q;
  assign bus.o_sram_dat    = wdat_q;
  assign bus.o_sram_dat_oe = doe_q;
  assign bus.o_sram_cs_n   = cs_n_q;
  assign bus.o_sram_oe_n   = oe_n_q;
  assign bus.o_sram_we_n   = we_n_q;
  assign bus.o_a_dat       = rd_q;
  assign bus.o_b_dat       = rd_q;
  assign bus.o_a_ack       = a_ack_q;
  assign bus.o_b_ack       = b_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with an SRAM model.
// Cycle k = the period following clock edge k after the request edge.
module tb_sram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  logic [7:0] mem [0:262143];

  sram_arbiter_if bus ();

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.i_sram_dat = !bus.o_sram_oe_n
                        ? mem[bus.o_sram_addr] : 8'h00;

  always @(posedge clk)
    if (!bus.o_sram_cs_n && !bus.o_sram_we_n &&
        bus.o_sram_dat_oe)
      mem[bus.o_sram_addr] <= bus.o_sram_dat;

  // Cycle-by-cycle safety properties
  always @(negedge clk) begin
    checks = checks + 1;
    if (bus.o_a_ack && bus.o_b_ack) begin
      fails = fails + 1;
      $display("FAIL both_acks t=%0t a=1 b=1 required not both", $time);
    end
    checks = checks + 1;
    if (!bus.o_sram_we_n && !bus.o_sram_oe_n) begin
      fails = fails + 1;
      $display("FAIL we_oe_overlap t=%0t we_n=0 oe_n=0", $time);
    end
    checks = checks + 1;
    if (bus.o_sram_dat_oe && !bus.o_sram_oe_n) begin
      fails = fails + 1;
      $display("FAIL bus_fight t=%0t dat_oe=1 oe_n=0", $time);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.i_a_cs   = 1'b0;
    bus.i_a_we   = 1'b0;
    bus.i_a_addr = 18'd0;
    bus.i_a_dat  = 8'd0;
    bus.i_b_cs   = 1'b0;
    bus.i_b_we   = 1'b0;
    bus.i_b_addr = 18'd0;
    bus.i_b_dat  = 8'd0;
  endtask

  task automatic test_reset;
    checks = checks + 1;
    if ({bus.o_sram_cs_n, bus.o_sram_oe_n,
         bus.o_sram_we_n, bus.o_sram_dat_oe,
         bus.o_a_ack, bus.o_b_ack} !== 6'b111000) begin
      fails = fails + 1;
      $display("FAIL reset_pins got cs/oe/we/doe/aa/ba=%b required 111000",
        {bus.o_sram_cs_n, bus.o_sram_oe_n, bus.o_sram_we_n,
         bus.o_sram_dat_oe, bus.o_a_ack, bus.o_b_ack});
    end
    checks = checks + 1;
    if (bus.o_sram_addr !== 18'd0 || bus.o_a_dat !== 8'h00) begin
      fails = fails + 1;
      $display("FAIL reset_regs got addr=%h dat=%h required 0/00",
        bus.o_sram_addr, bus.o_a_dat);
    end
    bus.i_a_cs   = 1'b1;
    bus.i_a_we   = 1'b1;
    bus.i_a_addr = 18'h00100;
    bus.i_a_dat  = 8'h11;
    tick;
    tick;
    checks = checks + 1;
    if (bus.o_sram_we_n !== 1'b0 || bus.o_sram_dat_oe !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL rst_pre_strobe got we_n=%b doe=%b required 0/1",
        bus.o_sram_we_n, bus.o_sram_dat_oe);
    end
    #3 rst = 1'b1;
    #1;
    checks = checks + 1;
    if ({bus.o_sram_cs_n, bus.o_sram_oe_n,
         bus.o_sram_we_n, bus.o_sram_dat_oe} !== 4'b1110) begin
      fails = fails + 1;
      $display("FAIL rst_async got cs/oe/we/doe=%b required 1110",
        {bus.o_sram_cs_n, bus.o_sram_oe_n,
         bus.o_sram_we_n, bus.o_sram_dat_oe});
    end
    checks = checks + 1;
    if (bus.o_a_ack !== 1'b0 || bus.o_a_dat !== 8'h00 ||
        bus.o_sram_addr !== 18'd0) begin
      fails = fails + 1;
      $display("FAIL rst_async_regs got ack=%b dat=%h addr=%h required 0/00/0",
        bus.o_a_ack, bus.o_a_dat, bus.o_sram_addr);
    end
    bus.i_a_cs = 1'b0;
    tick;
    tick;
    #2 rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      checks = checks + 1;
      if (bus.o_a_ack !== 1'b0 || bus.o_sram_cs_n !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL rst_no_ack k=%0d got ack=%b cs_n=%b required 0/1",
          k, bus.o_a_ack, bus.o_sram_cs_n);
      end
    end
  endtask

  task automatic test_read_a;
    logic exp_oe_n;
    logic exp_cs_n;
    logic exp_ack;
    bus.i_a_cs   = 1'b1;
    bus.i_a_we   = 1'b0;
    bus.i_a_addr = 18'h12345;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp_oe_n = !(k >= 1 && k <= 3);
      exp_cs_n = !(k >= 1 && k <= 4);
      exp_ack  = (k == 5);
      checks = checks + 1;
      if (bus.o_sram_oe_n !== exp_oe_n) begin
        fails = fails + 1;
        $display("FAIL rd_oe_n k=%0d got %b required %b",
          k, bus.o_sram_oe_n, exp_oe_n);
      end
      checks = checks + 1;
      if (bus.o_sram_cs_n !== exp_cs_n ||
          bus.o_sram_we_n !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL rd_cs_we k=%0d got cs_n=%b we_n=%b required %b/1",
          k, bus.o_sram_cs_n, bus.o_sram_we_n, exp_cs_n);
      end
      checks = checks + 1;
      if (bus.o_a_ack !== exp_ack || bus.o_b_ack !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL rd_ack k=%0d got a=%b b=%b required %b/0",
          k, bus.o_a_ack, bus.o_b_ack, exp_ack);
      end
      if (exp_cs_n == 1'b0) begin
        checks = checks + 1;
        if (bus.o_sram_addr !== 18'h12345) begin
          fails = fails + 1;
          $display("FAIL rd_addr k=%0d got %h required 12345",
            k, bus.o_sram_addr);
        end
      end
      if (k == 5) begin
        checks = checks + 1;
        if (bus.o_a_dat !== 8'hA5) begin
          fails = fails + 1;
          $display("FAIL rd_data got %h required a5", bus.o_a_dat);
        end
        bus.i_a_cs = 1'b0;
      end
    end
  endtask

  task automatic test_write_b;
    logic exp_we_n;
    logic exp_doe;
    logic exp_ack;
    bus.i_b_cs   = 1'b1;
    bus.i_b_we   = 1'b1;
    bus.i_b_addr = 18'h3FFFF;
    bus.i_b_dat  = 8'h5A;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp_we_n = !(k == 2 || k == 3);
      exp_doe  = (k >= 1 && k <= 4);
      exp_ack  = (k == 5);
      checks = checks + 1;
      if (bus.o_sram_we_n !== exp_we_n ||
          bus.o_sram_dat_oe !== exp_doe) begin
        fails = fails + 1;
        $display("FAIL wr_we_doe k=%0d got we_n=%b doe=%b required %b/%b",
          k, bus.o_sram_we_n, bus.o_sram_dat_oe, exp_we_n, exp_doe);
      end
      checks = checks + 1;
      if (bus.o_b_ack !== exp_ack || bus.o_a_ack !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL wr_ack k=%0d got b=%b a=%b required %b/0",
          k, bus.o_b_ack, bus.o_a_ack, exp_ack);
      end
      if (exp_doe) begin
        checks = checks + 1;
        if (bus.o_sram_addr !== 18'h3FFFF ||
            bus.o_sram_dat !== 8'h5A ||
            bus.o_sram_cs_n !== 1'b0) begin
          fails = fails + 1;
          $display("FAIL wr_bus k=%0d got addr=%h dat=%h cs_n=%b required 3ffff/5a/0",
            k, bus.o_sram_addr, bus.o_sram_dat, bus.o_sram_cs_n);
        end
      end
      if (k == 5) bus.i_b_cs = 1'b0;
    end
    checks = checks + 1;
    if (mem[18'h3FFFF] !== 8'h5A) begin
      fails = fails + 1;
      $display("FAIL wr_mem got %h required 5a", mem[18'h3FFFF]);
    end
  endtask

  task automatic test_contention;
    logic exp_a;
    logic exp_b;
    bus.i_a_cs   = 1'b1;
    bus.i_a_we   = 1'b0;
    bus.i_a_addr = 18'h00010;
    bus.i_b_cs   = 1'b1;
    bus.i_b_we   = 1'b1;
    bus.i_b_addr = 18'h00020;
    bus.i_b_dat  = 8'h77;
    for (int k = 1; k <= 26; k++) begin
      tick;
      exp_a = (k == 5) || (k == 17);
      exp_b = (k == 11) || (k == 23);
      checks = checks + 1;
      if (bus.o_a_ack !== exp_a || bus.o_b_ack !== exp_b) begin
        fails = fails + 1;
        $display("FAIL rr_ack k=%0d got a=%b b=%b required %b/%b",
          k, bus.o_a_ack, bus.o_b_ack, exp_a, exp_b);
      end
      if (exp_a) begin
        checks = checks + 1;
        if (bus.o_a_dat !== 8'h3C) begin
          fails = fails + 1;
          $display("FAIL rr_rdata k=%0d got %h required 3c", k, bus.o_a_dat);
        end
      end
      if (k == 23) begin
        bus.i_a_cs = 1'b0;
        bus.i_b_cs = 1'b0;
      end
    end
    checks = checks + 1;
    if (mem[18'h00020] !== 8'h77) begin
      fails = fails + 1;
      $display("FAIL rr_mem got %h required 77", mem[18'h00020]);
    end
  endtask

  task automatic test_reset_strobe;
    logic exp_we_n;
    logic exp_ack;
    bus.i_b_cs   = 1'b1;
    bus.i_b_we   = 1'b1;
    bus.i_b_addr = 18'h00200;
    bus.i_b_dat  = 8'h99;
    tick;
    tick;
    checks = checks + 1;
    if (bus.o_sram_we_n !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL rs_pre got we_n=%b required 0", bus.o_sram_we_n);
    end
    #3 rst = 1'b1;
    #1;
    checks = checks + 1;
    if (bus.o_sram_we_n !== 1'b1 || bus.o_sram_dat_oe !== 1'b0 ||
        bus.o_sram_cs_n !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL rs_async got we_n=%b doe=%b cs_n=%b required 1/0/1",
        bus.o_sram_we_n, bus.o_sram_dat_oe, bus.o_sram_cs_n);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks = checks + 1;
      if (bus.o_b_ack !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL rs_no_ack k=%0d got %b required 0", k, bus.o_b_ack);
      end
    end
    #3 rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp_we_n = !(k == 2 || k == 3);
      exp_ack  = (k == 5);
      checks = checks + 1;
      if (bus.o_sram_we_n !== exp_we_n || bus.o_b_ack !== exp_ack) begin
        fails = fails + 1;
        $display("FAIL rs_restart k=%0d got we_n=%b ack=%b required %b/%b",
          k, bus.o_sram_we_n, bus.o_b_ack, exp_we_n, exp_ack);
      end
      if (k == 1) begin
        checks = checks + 1;
        if (bus.o_sram_cs_n !== 1'b0 || bus.o_sram_dat_oe !== 1'b1) begin
          fails = fails + 1;
          $display("FAIL rs_setup got cs_n=%b doe=%b required 0/1",
            bus.o_sram_cs_n, bus.o_sram_dat_oe);
        end
      end
      if (k == 5) bus.i_b_cs = 1'b0;
    end
    checks = checks + 1;
    if (mem[18'h00200] !== 8'h99) begin
      fails = fails + 1;
      $display("FAIL rs_mem got %h required 99", mem[18'h00200]);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    bus.i_a_cs   = 1'b1;
    bus.i_a_we   = 1'b0;
    bus.i_a_addr = 18'h12345;
    for (int k = 1; k <= 14; k++) begin
      tick;
      exp_ack = (k == 5) || (k == 11);
      checks = checks + 1;
      if (bus.o_a_ack !== exp_ack || bus.o_b_ack !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL b2b_ack k=%0d got a=%b b=%b required %b/0",
          k, bus.o_a_ack, bus.o_b_ack, exp_ack);
      end
      if (k == 6 || k == 7) begin
        checks = checks + 1;
        if (bus.o_sram_cs_n !== (k == 6)) begin
          fails = fails + 1;
          $display("FAIL b2b_cs k=%0d got cs_n=%b required %b",
            k, bus.o_sram_cs_n, (k == 6));
        end
      end
      if (k == 11) bus.i_a_cs = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    mem[18'h12345] = 8'hA5;
    mem[18'h00010] = 8'h3C;
    mem[18'h00020] = 8'h00;
    mem[18'h00200] = 8'h00;
    mem[18'h3FFFF] = 8'h00;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick;
    test_reset();
    test_read_a();
    test_write_b();
    test_contention();
    test_reset_strobe();
    test_back_to_back();
    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
